// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between two burst requesters.
// Each grant runs a fixed-length wrapping burst; returned words are registered and tagged.
module rom_burst_arbiter #(
  parameter int WIDTH  = 8,
  parameter int NUMBER = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [NUMBER-1:0] addr0,
  input  logic [NUMBER-1:0] len0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [NUMBER-1:0] addr1,
  input  logic [NUMBER-1:0] len1,
  output logic              gnt1,
  output logic              rom_read,
  output logic [NUMBER-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid0,
  output logic              rd_valid1,
  output logic              rd_last,
  output logic              busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [NUMBER-1:0] cur_addr_q, cur_addr_d;
  logic [NUMBER-1:0] cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid0_q, rd_valid0_d;
  logic              rd_valid1_q, rd_valid1_d;
  logic              rd_last_q, rd_last_d;
  logic              pick1_s;

  // Requester 1 wins when it is alone or when both ask and it holds priority.
  assign pick1_s = req1 & (~req0 | prio_q);

  // Next-state and next-output computation for the arbiter/burst FSM.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    busy_d      = busy_q;
    rd_data_d   = rd_data_q;
    rd_valid0_d = 1'b0;
    rd_valid1_d = 1'b0;
    rd_last_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = BURST;
          owner_d    = pick1_s;
          prio_d     = ~pick1_s;
          cur_addr_d = pick1_s ? addr1 : addr0;
          cnt_d      = pick1_s ? len1 : len0;
          gnt0_d     = ~pick1_s;
          gnt1_d     = pick1_s;
          busy_d     = 1'b1;
        end else begin
          cur_addr_d = {NUMBER{1'b0}};
          busy_d     = 1'b0;
        end
      end
      BURST: begin
        rd_data_d   = rom_data;
        rd_valid0_d = ~owner_q;
        rd_valid1_d = owner_q;
        rd_last_d   = (cnt_q == {NUMBER{1'b0}});
        cnt_d       = cnt_q - NUMBER'(1);
        // The address register doubles as the ROM address, so it returns to 0 in IDLE.
        if (cnt_q == {NUMBER{1'b0}}) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          cur_addr_d = {NUMBER{1'b0}};
        end else begin
          cur_addr_d = cur_addr_q + NUMBER'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        cur_addr_d = {NUMBER{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      cur_addr_q  <= {NUMBER{1'b0}};
      cnt_q       <= {NUMBER{1'b0}};
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= {WIDTH{1'b0}};
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      busy_q      <= busy_d;
      rd_data_q   <= rd_data_d;
      rd_valid0_q <= rd_valid0_d;
      rd_valid1_q <= rd_valid1_d;
      rd_last_q   <= rd_last_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rom_read  = busy_q;
  assign busy      = busy_q;
  assign rom_addr  = cur_addr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid0 = rd_valid0_q;
  assign rd_valid1 = rd_valid1_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench: each round pushes expected grants and beats from a transaction-level
// model; independent monitors pop and compare whenever the DUT grants or returns a word.
module tb_rom_burst_arbiter;
  localparam int WIDTH  = 8;
  localparam int NUMBER = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, gnt0, gnt1;
  logic [NUMBER-1:0] addr0, len0, addr1, len1;
  logic              rom_read, rd_valid0, rd_valid1, rd_last, busy;
  logic [NUMBER-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data, rd_data;

  rom_burst_arbiter #(.WIDTH(WIDTH), .NUMBER(NUMBER)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1),
    .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_data(rd_data), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_last(rd_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM word[i] = i+1; 8'hEE stands in for the undriven bus so a stray capture is visible.
  always_comb rom_data = rom_read ? (8'(rom_addr) + 8'd1) : 8'hEE;

  typedef struct packed {logic owner; logic [7:0] data; logic last; logic first;} beat_t;
  typedef struct packed {logic owner; logic b2b; logic [2:0] addr;} gnt_t;

  beat_t exp_beats[$];
  gnt_t  exp_gnts[$];
  beat_t eb;
  gnt_t  eg;
  int    errors = 0, checks = 0;
  int    cyc = 0, last_end = -10, gnt_cyc = -10, beats_seen = 0;
  logic  model_prio = 1'b0;
  logic [7:0] last_data = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected/seen (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_onehot", 32'(rd_valid0 & rd_valid1), 32'd0);
      if (rd_valid0 || rd_valid1) begin
        if (exp_beats.size() == 0) fail("unexpected_beat");
        else begin
          eb = exp_beats.pop_front();
          check("beat_owner", 32'(rd_valid1), 32'(eb.owner));
          check("beat_data", 32'(rd_data), 32'(eb.data));
          check("beat_last", 32'(rd_last), 32'(eb.last));
          if (eb.first) check("beat_latency", 32'(cyc), 32'(gnt_cyc + 1));
          if (eb.last) last_end = cyc;
          beats_seen++;
          last_data = rd_data;
        end
      end else if (rd_last) begin
        fail("last_without_valid");
      end
    end
  end

  // Grant monitor.
  always @(negedge clk) begin
    if (rst_n && (gnt0 || gnt1)) begin
      check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
      if (exp_gnts.size() == 0) fail("unexpected_gnt");
      else begin
        eg = exp_gnts.pop_front();
        check("gnt_owner", 32'(gnt1), 32'(eg.owner));
        check("gnt_rom_addr", 32'(rom_addr), 32'(eg.addr));
        check("gnt_busy_read", 32'({busy, rom_read}), 32'd3);
        if (eg.b2b) check("gnt_bubble", 32'(cyc), 32'(last_end + 1));
      end
      gnt_cyc = cyc;
    end
  end

  task automatic expect_burst(input logic o, input logic [2:0] a, input logic [2:0] l, input logic b2b);
    exp_gnts.push_back('{owner: o, b2b: b2b, addr: a});
    for (int k = 0; k <= int'(l); k++)
      exp_beats.push_back('{owner: o, data: 8'(((int'(a) + k) % 8) + 1),
                            last: (k == int'(l)), first: (k == 0)});
    model_prio = ~o;
  endtask

  task automatic check_idle(input string name);
    check(name, 32'({busy, rom_read, rom_addr, rd_valid0, rd_valid1, rd_last, gnt0, gnt1}), 32'd0);
    check("idle_hold_data", 32'(rd_data), 32'(last_data));
  endtask

  task automatic run_round(input logic r0, input logic [2:0] a0, input logic [2:0] l0,
                           input logic r1, input logic [2:0] a1, input logic [2:0] l1);
    logic first1;
    int   n, budget;
    if (!r0 && !r1) begin
      repeat (3) @(negedge clk);
      check_idle("idle_no_req");
      return;
    end
    first1 = r1 & (~r0 | model_prio);
    n = 0;
    for (int g = 0; g < 2; g++) begin
      logic o;
      o = (g == 0) ? first1 : ~first1;
      if (o ? r1 : r0) begin
        expect_burst(o, o ? a1 : a0, o ? l1 : l0, n > 0);
        n++;
      end
    end
    req0 = r0; addr0 = a0; len0 = l0;
    req1 = r1; addr1 = a1; len1 = l1;
    budget = 0;
    while ((exp_beats.size() != 0 || req0 || req1) && budget < 300) begin
      @(negedge clk);
      #1;
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      budget++;
    end
    if (budget >= 300) begin
      fail("round_timeout");
      req0 = 1'b0; req1 = 1'b0;
      exp_beats.delete(); exp_gnts.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 3'd0; len0 = 3'd0; addr1 = 3'd0; len1 = 3'd0;
    #12;
    check_idle("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    run_round(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
    run_round(1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 3'd0);  // single burst 3,4,5,6
    run_round(1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 3'd2);  // wrap 7,8,1
    run_round(1'b1, 3'd1, 3'd0, 1'b1, 3'd4, 3'd0);  // contention 0 then 1
    run_round(1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 3'd0);
    run_round(1'b1, 3'd0, 3'd7, 1'b0, 3'd0, 3'd0);  // full depth 1..8

    // Full-depth burst abandoned by reset after its third beat.
    expect_burst(1'b0, 3'd0, 3'd7, 1'b0);
    req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
    budget = beats_seen + 3;
    for (int i = 0; i < 50 && beats_seen < budget; i++) begin
      @(negedge clk);
      #1;
      if (gnt0) req0 = 1'b0;
    end
    if (beats_seen < budget) fail("mid_reset_wait");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    last_data = 8'd0;
    check_idle("mid_reset_outputs");
    exp_beats.delete(); exp_gnts.delete();
    model_prio = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_held");
    rst_n = 1'b1;
    run_round(1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 3'd1);  // req1 alone after reset

    for (int r = 0; r < 40; r++)
      run_round(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom));

    run_round(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
    check("scoreboard_drained", 32'(exp_beats.size() + exp_gnts.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
